time_field_counter: RTL and testbench
=====================================

# time_field_counter

Parametrised modulo counter for one wall-clock field: seconds, minutes or hours. Instances are chained by `carry_out` -> `tick_in` to form the clock, and a second chain forms the alarm set-point. It advances on a carry pulse from the lower field and accepts user up/down adjustment with press-and-hold auto-repeat. It also supports a direct load. It presents the value in three registered forms: binary, packed two-digit BCD, and scaled (value × SCALE) for the display path.

## Interface
Parameters:
- `MODULUS`, 60: field wraps at MODULUS-1 -> 0. Legal range 2..100.
- `WIDTH`, 7: width of `value` and `load_value`. Must satisfy 2^WIDTH >= MODULUS.
- `SCALE`, 100: multiplier for `scaled`.
- `REPEAT_DELAY`, 500: cycles of continuous hold before auto-repeat starts (>= 2).
- `REPEAT_PERIOD`, 100: cycles between auto-repeat steps (>= 1).

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `enable`, input, 1: when high, `tick_in` is honoured.
- `tick_in`, input, 1: single-cycle carry from the lower field.
- `up`, input, 1: adjust-up button level, already synchronised and debounced.
- `down`, input, 1: adjust-down button level, already synchronised and debounced.
- `load`, input, 1: single-cycle load strobe.
- `load_value`, input, WIDTH: value to load.
- `value`, output, WIDTH: binary field value.
- `bcd`, output, 8: tens digit in [7:4], units digit in [3:0].
- `scaled`, output, 32: value × SCALE.
- `carry_out`, output, 1: single-cycle pulse on wrap caused by `tick_in`.

## Operation
- Update priority per cycle: `load` > `tick_in` (when `enable`=1) > adjust step.
- Load:
  - If `load_value` < MODULUS, `value` <= `load_value`.
  - If `load_value` >= MODULUS, the load is ignored and `value` is unchanged.
  - No `carry_out` from a load.
- Tick:
  - `value` increments by 1.
  - At MODULUS-1 the value wraps to 0 and `carry_out`=1 for exactly that cycle.
  - `tick_in` is ignored while `enable`=0.
- Adjust step:
  - Up step is +1, wrapping MODULUS-1 -> 0.
  - Down step is -1, wrapping 0 -> MODULUS-1.
  - An adjust step never asserts `carry_out` and never affects other fields.
- A step that loses priority to a load or tick is dropped, not deferred. The adjust FSM timing is unaffected.
- Adjust FSM:
  - Registers `up_q`, `down_q` hold the previous-cycle levels.
  - Cycle counter `rpt_cnt` is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - States:
    - IDLE: a press is exactly one of `up`/`down` high with that button low in the previous sample. A press issues one step, latches the direction, clears `rpt_cnt` and moves to DELAY.
    - DELAY: `rpt_cnt` increments. When `rpt_cnt` = REPEAT_DELAY-1, issue a step, clear `rpt_cnt` and move to REPEAT.
    - REPEAT: `rpt_cnt` increments. When `rpt_cnt` = REPEAT_PERIOD-1, issue a step and clear `rpt_cnt`.
  - From DELAY or REPEAT, return to IDLE with no step when the latched button goes low, or when both buttons are high.
  - Both buttons high in IDLE: no step, stay in IDLE. No new press is recognised until both are released.
  - Switching directly from `up` to `down` exits to IDLE. The new press is then recognised on the next cycle.
- Output encoding:
  - `bcd` = {value/10, value%10}.
  - `scaled` = value × SCALE, zero-extended to 32 bits.
  - `bcd` and `scaled` are registered and computed from the next value, so all three outputs change on the same edge.
- Reset: `value`=0, `bcd`=8'h00, `scaled`=0, `carry_out`=0, FSM=IDLE, `rpt_cnt`=0, `up_q`=`down_q`=0.
  - Reset mid-hold aborts the repeat.
  - A button still held after reset is treated as a new press on the first cycle it is sampled high after `reset` deasserts. With `up_q`=0 after reset, that is the first cycle after reset.

## Timing
- Single clock domain; all outputs registered. `carry_out` is a registered pulse, high for one cycle.
- Tick or load at edge N -> new `value`, `bcd` and `scaled` visible after edge N. `carry_out` is high during the same cycle as the wrapped value.
- Press sampled at edge N (current sample high, previous sample low) -> first step visible after edge N.
- While the button is held, auto-repeat steps occur at edge N+REPEAT_DELAY, then every REPEAT_PERIOD edges after that.
- Chained fields: a lower field's `carry_out` in cycle C increments the upper field at the end of cycle C. Ripple is one cycle per field.

## Test plan
Bench parameters: MODULUS=60, REPEAT_DELAY=4, REPEAT_PERIOD=2.
- Reset, then 59 `tick_in` pulses with `enable`=1 -> `value`=59, `bcd`=8'h59, `scaled`=5900, `carry_out` never high. The 60th pulse -> `value`=0, `carry_out`=1 for one cycle.
- `tick_in` with `enable`=0 -> `value` unchanged. Load 42 -> `bcd`=8'h42, `scaled`=4200. Load 75 -> `value` stays 42.
- From 0, a single 1-cycle `down` press -> `value`=59, no `carry_out`. Then `up` press -> `value`=0, no `carry_out`.
- Hold `up` for 10 cycles from 10 -> steps at press edges +0, +4, +6, +8, giving final `value`=14. After release, no further steps.
- `tick_in` coincident with an up step at 20 -> `value`=21 (step dropped). `load`=5 coincident with `tick_in` -> `value`=5.
- Both buttons high from IDLE -> no change. Assert `reset` mid-repeat with `up` held -> outputs 0. `value`=1 on the first cycle after `reset` deasserts, then repeat steps at +4 and +6.

Source files
------------

// File: rtl/time_field_counter.sv
// time_field_counter: one wall-clock field with tick carry, direct load and press-and-hold adjust
module time_field_counter #(
    parameter int MODULUS       = 60,
    parameter int WIDTH         = 7,
    parameter int SCALE         = 100,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic [7:0]       bcd,
    output logic [31:0]      scaled,
    output logic             carry_out
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW = $clog2(RMAX);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_up_q, r_down_q, r_dir_dn, w_dir_nxt;
    logic             w_press_up, w_press_dn, w_exit, w_switch, w_hit;
    logic             w_step, w_step_dn, w_carry;
    logic [WIDTH-1:0] r_value, w_next;
    logic [7:0]       r_bcd;
    logic [31:0]      r_scaled, w_next32;
    logic             r_carry;

    assign w_press_up = up & ~down & ~r_up_q;
    assign w_press_dn = down & ~up & ~r_down_q;
    assign w_exit     = (r_dir_dn ? ~down : ~up) | (up & down);
    assign w_switch   = (r_state != S_IDLE) & (up ^ down) & (r_dir_dn ? up : down);
    assign w_hit      = (r_state == S_DELAY) ? (r_cnt == CW'(REPEAT_DELAY - 1))
                                             : (r_cnt == CW'(REPEAT_PERIOD - 1));
    assign w_next32   = 32'(w_next);

    // adjust FSM state, repeat counter and button history; a direct up/down switch
    // clears the history so the new button counts as a fresh press next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dir_dn <= 1'b0;
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir_dn <= w_dir_nxt;
            r_up_q   <= up & ~w_switch;
            r_down_q <= down & ~w_switch;
        end
    end

    // next adjust state: press starts the hold, release or both-high aborts it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_dir_nxt   = r_dir_dn;
        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
            if (w_press_up | w_press_dn) begin
                w_state_nxt = S_DELAY;
                w_dir_nxt   = w_press_dn;
            end
        end else if (w_exit) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_hit) begin
            w_state_nxt = S_REPEAT;
            w_cnt_nxt   = '0;
        end
    end

    // adjust step request and its direction
    always_comb begin
        w_step    = (r_state == S_IDLE) ? (w_press_up | w_press_dn) : (~w_exit & w_hit);
        w_step_dn = (r_state == S_IDLE) ? w_press_dn : r_dir_dn;
    end

    // next field value: load beats tick beats adjust; losing steps are dropped
    always_comb begin
        w_next  = r_value;
        w_carry = 1'b0;
        if (load) begin
            w_next = (32'(load_value) < 32'(MODULUS)) ? load_value : r_value;
        end else if (tick_in & enable) begin
            w_next  = (r_value == TOP) ? '0 : r_value + WIDTH'(1);
            w_carry = (r_value == TOP);
        end else if (w_step) begin
            w_next = w_step_dn ? ((r_value == '0) ? TOP : r_value - WIDTH'(1))
                               : ((r_value == TOP) ? '0 : r_value + WIDTH'(1));
        end
    end

    // all output forms registered from the same next value so they change together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= '0;
            r_bcd    <= 8'h00;
            r_scaled <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_value  <= w_next;
            r_bcd    <= {4'(w_next32 / 32'd10), 4'(w_next32 % 32'd10)};
            r_scaled <= w_next32 * 32'(SCALE);
            r_carry  <= w_carry;
        end
    end

    assign value     = r_value;
    assign bcd       = r_bcd;
    assign scaled    = r_scaled;
    assign carry_out = r_carry;
endmodule

// File: tb/tb_time_field_counter.sv
// tb_time_field_counter: directed plus random checks of time_field_counter against a hold-length model
module tb_time_field_counter;
    localparam int MOD = 60;
    localparam int RD  = 4;
    localparam int RP  = 2;

    logic        clk = 1'b0;
    logic        reset, enable, tick_in, up, down, load;
    logic [6:0]  load_value;
    logic [6:0]  value;
    logic [7:0]  bcd;
    logic [31:0] scaled;
    logic        carry_out;

    int tests = 0;
    int fails = 0;
    string phase = "init";

    int m_v = 0;
    bit m_c = 0;
    bit m_act = 0, m_dn = 0, m_pu = 0, m_pd = 0, m_sw = 0;
    int m_len = 0;

    always #5 clk = ~clk;

    time_field_counter #(
        .MODULUS(MOD), .WIDTH(7), .SCALE(100), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick_in(tick_in), .up(up), .down(down),
        .load(load), .load_value(load_value), .value(value), .bcd(bcd), .scaled(scaled),
        .carry_out(carry_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    // behavioural model: a held button steps at hold length 0, RD, RD+RP, RD+2RP, ...
    task automatic model_edge();
        bit step = 0, sdn = 0, sw_now = 0;
        bit u = up, d = down;
        if (reset) begin
            m_v = 0; m_c = 0; m_act = 0; m_pu = 0; m_pd = 0; m_sw = 0; m_len = 0;
            return;
        end
        if (m_act) begin
            if ((u && d) || !(m_dn ? d : u)) begin
                m_act = 0;
                sw_now = (u != d);
            end else begin
                m_len++;
                if (m_len == RD || (m_len > RD && (m_len - RD) % RP == 0)) begin
                    step = 1; sdn = m_dn;
                end
            end
        end else if (u != d && ((u ? !m_pu : !m_pd) || m_sw)) begin
            m_act = 1; m_dn = d; m_len = 0; step = 1; sdn = d;
        end
        m_sw = sw_now; m_pu = u; m_pd = d;
        m_c = 0;
        if (load) begin
            if (load_value < MOD) m_v = load_value;
        end else if (tick_in && enable) begin
            m_c = (m_v == MOD - 1);
            m_v = (m_v + 1) % MOD;
        end else if (step) begin
            m_v = sdn ? (m_v + MOD - 1) % MOD : (m_v + 1) % MOD;
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit t, input bit u, input bit d,
                       input bit l, input int lv, input int n = 1);
        repeat (n) begin
            reset = r; enable = e; tick_in = t; up = u; down = d; load = l;
            load_value = 7'(lv);
            @(posedge clk);
            model_edge();
            #1;
            chk("value", 32'(value), m_v);
            chk("bcd", 32'(bcd), ((m_v / 10) << 4) | (m_v % 10));
            chk("scaled", scaled, m_v * 100);
            chk("carry", 32'(carry_out), 32'(m_c));
        end
    endtask

    initial begin
        bit ru = 0, rdn = 0;
        phase = "reset";
        cyc(1, 0, 0, 0, 0, 0, 0, 2);
        chk("rst_value", 32'(value), 0);
        chk("rst_bcd", 32'(bcd), 32'h00);
        phase = "tick59";
        cyc(0, 1, 1, 0, 0, 0, 0, 59);
        chk("v59", 32'(value), 59);
        chk("bcd59", 32'(bcd), 32'h59);
        chk("scaled59", scaled, 5900);
        phase = "tick60";
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("wrap_value", 32'(value), 0);
        chk("wrap_carry", 32'(carry_out), 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("carry_drop", 32'(carry_out), 0);
        phase = "disabled";
        cyc(0, 0, 1, 0, 0, 0, 0, 3);
        phase = "load";
        cyc(0, 1, 0, 0, 0, 1, 42);
        chk("bcd42", 32'(bcd), 32'h42);
        chk("scaled42", scaled, 4200);
        cyc(0, 1, 0, 0, 0, 1, 75);
        chk("load75_ignored", 32'(value), 42);
        phase = "single_press";
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);
        chk("down_wrap", 32'(value), 59);
        cyc(0, 1, 0, 0, 0, 0, 0, 3);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("up_wrap", 32'(value), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 3);
        phase = "hold";
        cyc(0, 1, 0, 0, 0, 1, 10);
        cyc(0, 1, 0, 1, 0, 0, 0, 10);
        chk("hold14", 32'(value), 14);
        cyc(0, 1, 0, 0, 0, 0, 0, 6);
        chk("after_release", 32'(value), 14);
        phase = "priority";
        cyc(0, 1, 0, 0, 0, 1, 20);
        cyc(0, 1, 1, 1, 0, 0, 0);
        chk("tick_beats_step", 32'(value), 21);
        cyc(0, 1, 0, 0, 0, 0, 0, 2);
        cyc(0, 1, 1, 0, 0, 1, 5);
        chk("load_beats_tick", 32'(value), 5);
        phase = "both";
        cyc(0, 1, 0, 1, 1, 0, 0, 6);
        chk("both_nochange", 32'(value), 5);
        cyc(0, 1, 0, 0, 0, 0, 0, 2);
        phase = "switch";
        cyc(0, 1, 0, 1, 0, 0, 0, 5);
        cyc(0, 1, 0, 0, 1, 0, 0, 8);
        cyc(0, 1, 0, 0, 0, 0, 0, 2);
        phase = "reset_hold";
        cyc(0, 1, 0, 0, 0, 1, 5);
        cyc(0, 1, 0, 1, 0, 0, 0, 7);
        cyc(1, 1, 0, 1, 0, 0, 0, 2);
        chk("rst_mid", 32'(value), 0);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("post_rst_press", 32'(value), 1);
        cyc(0, 1, 0, 1, 0, 0, 0, 3);
        chk("post_rst_p3", 32'(value), 1);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("post_rst_p4", 32'(value), 2);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("post_rst_p5", 32'(value), 2);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("post_rst_p6", 32'(value), 3);
        cyc(0, 1, 0, 0, 0, 0, 0, 2);
        phase = "random";
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) ru = ~ru;
            if ($urandom_range(7) == 0) rdn = ~rdn;
            cyc($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
                ru, rdn, $urandom_range(19) == 0, int'($urandom_range(127)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
